// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and default sizing; imported by the ROB and the issuer.
package rob_pkg;

    localparam int unsigned DEF_ROB_DEPTH = 8;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_AREG_W    = 4;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic [DEF_AREG_W-1:0] dest;
        logic [DEF_DATA_W-1:0] val;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order completion via the CDB,
// in-order single-entry-per-cycle retirement.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = DEF_ROB_DEPTH,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned AREG_W    = DEF_AREG_W,
    localparam int unsigned PTR_W    = $clog2(ROB_DEPTH),
    localparam int unsigned CNT_W    = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [AREG_W-1:0] alloc_dest,
    output logic              alloc_ready,
    output logic [PTR_W-1:0]  alloc_robid,
    input  logic              cdbtransmit,
    input  logic [PTR_W-1:0]  cdbid,
    input  logic [DATA_W-1:0] cdbval,
    input  logic              flush,
    output logic              commit_valid,
    output logic [AREG_W-1:0] commit_dest,
    output logic [DATA_W-1:0] commit_val,
    output logic [PTR_W-1:0]  commit_robid,
    output logic [CNT_W-1:0]  count
);

    // Same layout as rob_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic              valid;
        logic              done;
        logic [AREG_W-1:0] dest;
        logic [DATA_W-1:0] val;
    } entry_t;

    entry_t            entries_q [ROB_DEPTH];
    entry_t            entries_d [ROB_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              commit_valid_q, commit_valid_d;
    logic [AREG_W-1:0] commit_dest_q, commit_dest_d;
    logic [DATA_W-1:0] commit_val_q, commit_val_d;
    logic [PTR_W-1:0]  commit_robid_q, commit_robid_d;
    logic              alloc_fire;
    logic              commit_fire;

    assign alloc_ready = (count_q < CNT_W'(ROB_DEPTH)) && !flush;
    assign alloc_robid = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = !flush && entries_q[head_q].valid && entries_q[head_q].done;

    always_comb begin
        entries_d      = entries_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = 1'b0;
        commit_dest_d  = commit_dest_q;
        commit_val_d   = commit_val_q;
        commit_robid_d = commit_robid_q;

        if (flush) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].done  = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Registered valid gates completion, so a same-cycle alloc of cdbid is ignored.
            if (cdbtransmit && entries_q[cdbid].valid) begin
                entries_d[cdbid].done = 1'b1;
                entries_d[cdbid].val  = cdbval;
            end
            if (commit_fire) begin
                commit_valid_d          = 1'b1;
                commit_dest_d           = entries_q[head_q].dest;
                commit_val_d            = entries_q[head_q].val;
                commit_robid_d          = head_q;
                entries_d[head_q].valid = 1'b0;
                entries_d[head_q].done  = 1'b0;
                head_d                  = head_q + 1'b1;
            end
            if (alloc_fire) begin
                entries_d[tail_q] = '{valid: 1'b1, done: 1'b0, dest: alloc_dest, val: '0};
                tail_d            = tail_q + 1'b1;
            end
            unique case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_dest_q  <= '0;
            commit_val_q   <= '0;
            commit_robid_q <= '0;
        end else begin
            entries_q      <= entries_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_dest_q  <= commit_dest_d;
            commit_val_q   <= commit_val_d;
            commit_robid_q <= commit_robid_d;
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_dest  = commit_dest_q;
    assign commit_val   = commit_val_q;
    assign commit_robid = commit_robid_q;
    assign count        = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based in-flight list predicts retirements.
module tb_reorder_buffer;

    localparam int D  = 8;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_valid = 1'b0;
    logic [AW-1:0] alloc_dest = '0;
    logic          alloc_ready;
    logic [PW-1:0] alloc_robid;
    logic          cdbtransmit = 1'b0;
    logic [PW-1:0] cdbid = '0;
    logic [DW-1:0] cdbval = '0;
    logic          flush = 1'b0;
    logic          commit_valid;
    logic [AW-1:0] commit_dest;
    logic [DW-1:0] commit_val;
    logic [PW-1:0] commit_robid;
    logic [PW:0]   count;

    reorder_buffer #(.ROB_DEPTH(D), .DATA_W(DW), .AREG_W(AW)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_robid(alloc_robid),
        .cdbtransmit(cdbtransmit), .cdbid(cdbid), .cdbval(cdbval),
        .flush(flush),
        .commit_valid(commit_valid), .commit_dest(commit_dest),
        .commit_val(commit_val), .commit_robid(commit_robid),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int robid;
        int dest;
        bit done;
        int val;
    } ent_t;

    typedef struct {
        int dest;
        int val;
        int robid;
    } cmt_t;

    ent_t rob[$];
    cmt_t exp_q[$];
    int   tail_m = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, advance the model, then check at the falling edge.
    task automatic step(input bit r, input bit fl, input bit av, input int ad,
                        input bit ct, input int cid, input int cv);
        bit exp_cv = 0;
        int n0;
        rst         = r;
        flush       = fl;
        alloc_valid = av;
        alloc_dest  = ad[AW-1:0];
        cdbtransmit = ct;
        cdbid       = cid[PW-1:0];
        cdbval      = cv[DW-1:0];
        if (r || fl) begin
            rob.delete();
            tail_m = 0;
        end else begin
            n0 = rob.size();
            if (n0 > 0 && rob[0].done) begin
                exp_q.push_back('{dest: rob[0].dest, val: rob[0].val, robid: rob[0].robid});
                rob.pop_front();
                exp_cv = 1;
            end
            if (ct) begin
                foreach (rob[i]) begin
                    if (rob[i].robid == cid) begin
                        rob[i].done = 1;
                        rob[i].val  = cv & ((1 << DW) - 1);
                    end
                end
            end
            if (av && n0 < D) begin
                rob.push_back('{robid: tail_m, dest: ad & ((1 << AW) - 1), done: 0, val: 0});
                tail_m = (tail_m + 1) % D;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("count", int'(count), rob.size());
        chk("alloc_ready", int'(alloc_ready), (rob.size() < D && !fl) ? 1 : 0);
        chk("alloc_robid", int'(alloc_robid), tail_m);
        chk("commit_valid", int'(commit_valid), int'(exp_cv));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input int d);
        step(0, 0, 1, d, 0, 0, 0);
    endtask

    task automatic complete(input int id, input int v);
        step(0, 0, 0, 0, 1, id, v);
    endtask

    always @(negedge clk) begin
        if (commit_valid === 1'b1) begin
            cmt_t e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL commit_unexpected: got dest=%0d val=%0h robid=%0d expected none",
                         commit_dest, commit_val, commit_robid);
            end else begin
                e = exp_q.pop_front();
                if (int'(commit_dest) != e.dest || int'(commit_val) != e.val ||
                    int'(commit_robid) != e.robid) begin
                    n_bad++;
                    $display("FAIL commit_payload: got dest=%0d val=%0h robid=%0d expected dest=%0d val=%0h robid=%0d",
                             commit_dest, commit_val, commit_robid, e.dest, e.val, e.robid);
                end
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_commit_dest", int'(commit_dest), 0);
        chk("rst_commit_val", int'(commit_val), 0);
        chk("rst_commit_robid", int'(commit_robid), 0);

        // In-order retirement
        alloc(3); alloc(5); alloc(7);
        complete(0, 'h11); complete(1, 'h22); complete(2, 'h33);
        idle(3);

        // Out-of-order completion, in-order commit
        step(1, 0, 0, 0, 0, 0, 0);
        alloc(1); alloc(2);
        complete(1, 'hBB);
        idle(2);
        complete(0, 'hAA);
        idle(3);

        // Full, refused ninth alloc, retire and wrap
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < D; i++) alloc(i + 1);
        alloc(9);
        complete(0, 'h5A);
        idle(2);
        alloc(10);
        step(1, 0, 0, 0, 0, 0, 0);

        // Completion to an empty ROB
        step(0, 0, 0, 0, 1, 4, 'h77);
        idle(1);

        // Flush together with a completion
        alloc(4); alloc(6); alloc(8);
        complete(0, 'h44);
        step(0, 1, 1, 2, 1, 1, 'h99);
        chk("flush_commit_valid", int'(commit_valid), 0);
        idle(2);

        // Reset with five entries in flight
        for (int i = 0; i < 5; i++) alloc(11 + i);
        complete(0, 'hC3);
        complete(2, 'h3C);
        step(1, 0, 1, 1, 1, 1, 'h66);
        chk("mid_rst_commit_dest", int'(commit_dest), 0);
        chk("mid_rst_commit_val", int'(commit_val), 0);
        chk("mid_rst_commit_robid", int'(commit_robid), 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            bit r  = ($urandom_range(0, 199) == 0);
            bit fl = ($urandom_range(0, 59) == 0);
            bit av = ($urandom_range(0, 99) < 60);
            bit ct = ($urandom_range(0, 99) < 55);
            int cid = $urandom_range(0, D - 1);
            if (ct && rob.size() > 0 && $urandom_range(0, 3) != 0)
                cid = rob[$urandom_range(0, rob.size() - 1)].robid;
            step(r, fl, av, $urandom_range(0, (1 << AW) - 1), ct, cid, $urandom_range(0, 255));
        end

        // Drain: complete everything still in flight, then let it retire
        for (int k = 0; k < 3 * D && rob.size() > 0; k++) begin
            int id = rob[0].robid;
            foreach (rob[i]) if (!rob[i].done) begin id = rob[i].robid; break; end
            complete(id, $urandom_range(0, 255));
        end
        idle(D + 2);
        chk("drain_rob_empty", rob.size(), 0);
        chk("drain_scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 8: entry count, a power of two of at least 2.
REQ-002 SHALL have parameter DATA_W, default 8: result width.
REQ-003 SHALL have parameter AREG_W, default 4: architectural destination register index width.
REQ-004 SHALL have port clk, input, 1: single clock, with all state updated on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port alloc_valid, input, 1: dispatch requests an entry.
REQ-007 SHALL have port alloc_dest, input, AREG_W: destination register of the dispatched instruction.
REQ-008 SHALL have port alloc_ready, output, 1: combinational, high when count < ROB_DEPTH and flush=0.
REQ-009 SHALL have port alloc_robid, output, clog2(ROB_DEPTH): combinational, equal to the tail index; the issuer's robid takes this value.
REQ-010 SHALL have port cdbtransmit, input, 1: completion broadcast valid.
REQ-011 SHALL have port cdbid, input, clog2(ROB_DEPTH): robid of the completing entry.
REQ-012 SHALL have port cdbval, input, DATA_W: result value.
REQ-013 SHALL have port flush, input, 1: discard all entries.
REQ-014 SHALL have port commit_valid, output, 1: registered one-cycle pulse per retired entry.
REQ-015 SHALL have ports commit_dest (AREG_W), commit_val (DATA_W) and commit_robid (clog2(ROB_DEPTH)), all outputs: registered payload of the retired entry.
REQ-016 SHALL have port count, output, clog2(ROB_DEPTH)+1: registered occupancy.

Function
REQ-017 SHALL use a circular buffer: head = oldest entry, tail = next free entry; each entry holds valid, done, dest and val.
REQ-018 SHALL allocate on an edge where alloc_valid & alloc_ready: entry[tail] <= {valid=1, done=0, dest=alloc_dest}, tail advances by one.
REQ-019 SHALL, on an edge where cdbtransmit=1, set done=1 and val=cdbval on entry[cdbid] only if that entry is already valid; otherwise the broadcast is ignored.
REQ-020 SHALL treat a completion in the same cycle as allocation of the same index as a broadcast to an invalid entry, and ignore it.
REQ-021 SHALL retire when, at an edge, entry[head] is valid and done: register commit_valid=1 with that entry's dest, val and robid, clear the entry, and advance head; commit_valid is 0 on every other edge.
REQ-022 SHALL retire at most one entry per cycle; completion-to-commit latency is exactly 1 edge after done is set when the entry is at head.
REQ-023 SHALL compute alloc_ready from the registered count, so a full ROB refuses allocation even in a cycle where a commit occurs.
REQ-024 SHALL update count = count + alloc_fire - commit_fire; simultaneous alloc and commit leave count unchanged.
REQ-025 SHALL let head and tail wrap modulo ROB_DEPTH, with full/empty distinguished by count.
REQ-026 SHALL, when flush=1 at an edge, clear all valid bits, set head=tail=count=0 and commit_valid=0, and ignore that cycle's allocation and completion.
REQ-027 SHALL leave entries that are done but not at head waiting; out-of-order completion never causes out-of-order commit.

Reset
REQ-028 SHALL, when rst=1 at an edge, set head=tail=count=0, clear every entry's valid and done bits, and set commit_valid=0 and commit_dest=commit_val=commit_robid=0.
REQ-029 SHALL let rst override flush, alloc_valid and cdbtransmit in the same cycle; reset asserted mid-operation discards all in-flight entries.

Structure
REQ-030 SHALL define the rob_entry_t struct (valid, done, dest, val) and the ROB_DEPTH, DATA_W and AREG_W defaults in the shared package rob_pkg, which the issuer also imports.
REQ-031 SHALL be one flat module with no sub-module; head/tail/count logic is inline.

Verification
REQ-032 SHALL verify in-order retirement: alloc dest 3, 5, 7 (robids 0, 1, 2); complete robid 0 val 0x11, 1 val 0x22, 2 val 0x33 -> three commit pulses in order with (3,0x11), (5,0x22), (7,0x33).
REQ-033 SHALL verify out-of-order completion: alloc 2 entries; complete robid 1 val 0xBB, then robid 0 val 0xAA -> no commit until robid 0 completes, then commits robid 0 (0xAA) then robid 1 (0xBB) on consecutive cycles.
REQ-034 SHALL verify full and wrap: 8 allocs -> alloc_ready=0 and count=8; a 9th alloc is refused; complete and retire robid 0 -> alloc_ready=1, and the next alloc_robid is 0.
REQ-035 SHALL verify an invalid completion: cdbtransmit with cdbid 4 on an empty ROB -> no state change and count=0.
REQ-036 SHALL verify flush: 3 entries allocated, robid 0 done; flush in the same cycle as a completion -> next cycle count=0, commit_valid=0, alloc_robid=0.
REQ-037 SHALL verify reset mid-operation: rst asserted with 5 entries in flight -> all outputs return to their REQ-028 values one edge later.
